// File: rtl/priority_encoder_rr_pkg.sv
// Shared constants and helpers for the N-request priority encoder / arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package priority_encoder_pkg;

    // Arbitration mode encoding carried on rr_mode.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width that stays at least one bit wide even for tiny request counts.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : priority_encoder_pkg

// File: rtl/priority_encoder_rr_if.sv
// Request/grant bundle between request sources, the arbiter and the grant consumer.
// Latency: n/a (wiring only).
// Backpressure: grant_ready from the consumer freezes the registered grant.
//
// Ports (signals):
//   req          - request vector, bit i = requester i
//   rr_mode      - 0 = fixed priority (highest index wins), 1 = round-robin
//   grant_ready  - consumer accepts the current grant
//   grant_valid  - registered grant present
//   grant_idx    - index of the granted requester
//   grant_onehot - one-hot form of grant_idx, zero when grant_valid = 0
interface priority_encoder_rr_if #(
    parameter int N_REQ = 8
);
    import priority_encoder_pkg::*;

    localparam int IDX_W = idx_width(N_REQ);

    logic [N_REQ-1:0] req;
    logic             rr_mode;
    logic             grant_ready;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_onehot;

    // Request side / consumer drives requests and ready.
    modport master (
        output req,
        output rr_mode,
        output grant_ready,
        input  grant_valid,
        input  grant_idx,
        input  grant_onehot
    );

    // Arbiter side produces the grant.
    modport slave (
        input  req,
        input  rr_mode,
        input  grant_ready,
        output grant_valid,
        output grant_idx,
        output grant_onehot
    );

endinterface : priority_encoder_rr_if

// File: rtl/priority_encoder_rr_search.sv
// Combinational search for the first set request bit, scanning downward with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is registered.
//
// Ports:
//   i_req    - request vector
//   i_start  - first index examined in round-robin mode (ignored in fixed mode)
//   i_mode   - MODE_FIXED scans from N_REQ-1, MODE_RR scans from i_start
//   o_found  - at least one request bit is set
//   o_winner - index of the first set bit in scan order, 0 when none
module pe_rotate_search
    import priority_encoder_pkg::*;
#(
    parameter int N_REQ = 8,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    input  logic             i_mode,
    output logic             o_found,
    output logic [IDX_W-1:0] o_winner
);

    int w_start;
    int w_pos;

    // Scan order: start, start-1, ..., 0, N_REQ-1, ..., start+1.
    // Fixed mode is the same scan anchored at N_REQ-1, so one loop covers both.
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_pos    = 0;
        w_start  = (i_mode == MODE_RR) ? int'(i_start) : (N_REQ - 1);
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = w_start - k;
            if (w_pos < 0) begin
                w_pos = w_pos + N_REQ;
            end
            if (!o_found && i_req[w_pos[IDX_W-1:0]]) begin
                o_found  = 1'b1;
                o_winner = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule : pe_rotate_search

// File: rtl/priority_encoder_rr.sv
// N-request arbiter with fixed-priority / round-robin modes and a registered grant.
// Latency: 1 cycle from req to grant_valid; one grant per cycle when ready is held high.
// Backpressure: grant_ready low freezes grant_idx/grant_onehot; req changes are ignored until handshake.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; drops any held grant, ptr -> N_REQ-1
//   bus - priority_encoder_rr_if slave (req, rr_mode, grant_ready in; grant_* out)
module priority_encoder_rr
    import priority_encoder_pkg::*;
#(
    parameter int N_REQ = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    priority_encoder_rr_if.slave bus
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);

    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [N_REQ-1:0] r_onehot;
    logic             r_rr;      // current grant was issued in round-robin mode
    logic [IDX_W-1:0] r_ptr;

    logic             w_hs;
    logic             w_eval;
    logic [IDX_W-1:0] w_ptr_next;
    logic             w_found;
    logic [IDX_W-1:0] w_winner;
    logic [N_REQ-1:0] w_win_onehot;

    assign w_hs   = r_valid & bus.grant_ready;
    assign w_eval = ~r_valid | bus.grant_ready;

    // The pointer moves only when a round-robin grant is accepted. The search in
    // the same cycle must already see the moved pointer, otherwise back-to-back
    // round-robin grants would repeat the winner just served.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_hs && r_rr) begin
            w_ptr_next = (r_idx == '0) ? PTR_INIT : (r_idx - IDX_W'(1));
        end
    end

    pe_rotate_search #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_search (
        .i_req    (bus.req),
        .i_start  (w_ptr_next),
        .i_mode   (bus.rr_mode),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    always_comb begin
        w_win_onehot           = '0;
        w_win_onehot[w_winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_rr     <= 1'b0;
            r_ptr    <= PTR_INIT;
        end else begin
            r_ptr <= w_ptr_next;
            if (w_eval) begin
                r_valid  <= w_found;
                r_idx    <= w_found ? w_winner : '0;
                r_onehot <= w_found ? w_win_onehot : '0;
                r_rr     <= (bus.rr_mode == MODE_RR);
            end
        end
    end

    assign bus.grant_valid  = r_valid;
    assign bus.grant_idx    = r_idx;
    assign bus.grant_onehot = r_onehot;

endmodule : priority_encoder_rr

// File: tb/tb_priority_encoder_rr.sv
// Scoreboard bench for priority_encoder_rr (N_REQ = 8).
// Latency: stimulus pushes expected handshake indices; the monitor pops on each accepted grant.
// Backpressure: grant_ready is driven per scenario to exercise hold and back-to-back flow.
module tb_priority_encoder_rr;

    localparam int N = 8;

    logic clk;
    logic rst;

    priority_encoder_rr_if #(.N_REQ(N)) bus ();

    priority_encoder_rr #(.N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.grant_ready = 1'b0;
        cycle();
    endtask

    // Monitor: compares every accepted grant against the scoreboard and checks
    // the one-hot / index invariants on every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.grant_valid) begin
                chk("onehot_matches_idx", 64'(bus.grant_onehot), 64'(1) << bus.grant_idx);
                if (bus.grant_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_grant: got idx %0d, expected none", bus.grant_idx);
                    end else begin
                        chk("handshake_idx", 64'(bus.grant_idx), 64'(exp_q.pop_front()));
                    end
                end
            end else begin
                chk("idle_onehot_zero", 64'(bus.grant_onehot), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.req         = '0;
        bus.rr_mode     = 1'b0;
        bus.grant_ready = 1'b0;

        // Reset and hold: outputs stay clear while rst is high, even with requests.
        bus.req = 8'hFF;
        cycle();
        chk("rst_valid", 64'(bus.grant_valid), 64'd0);
        chk("rst_idx", 64'(bus.grant_idx), 64'd0);
        chk("rst_onehot", 64'(bus.grant_onehot), 64'd0);
        chk("rst_ptr", 64'(dut.r_ptr), 64'd7);
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_valid", 64'(bus.grant_valid), 64'd1);
        chk("post_rst_idx", 64'(bus.grant_idx), 64'd7);

        // Fixed mode: highest set bit (5) wins every cycle; pointer untouched.
        do_reset();
        bus.rr_mode = 1'b0; bus.req = 8'b0010_0110; bus.grant_ready = 1'b1;
        repeat (4) exp_q.push_back(5);
        rst = 1'b0;
        repeat (4) cycle();
        bus.req = '0;
        cycle();
        chk("fixed_empty_valid", 64'(bus.grant_valid), 64'd0);
        chk("fixed_empty_idx", 64'(bus.grant_idx), 64'd0);
        chk("fixed_ptr", 64'(dut.r_ptr), 64'd7);

        // Round-robin fairness: all requesting, 7 down to 0 then wrap to 7.
        do_reset();
        bus.rr_mode = 1'b1; bus.req = 8'hFF; bus.grant_ready = 1'b1;
        for (int i = 7; i >= 0; i--) exp_q.push_back(i);
        exp_q.push_back(7);
        rst = 1'b0;
        repeat (10) cycle();
        bus.grant_ready = 1'b0;

        // Backpressure: grant 3 held while req[3] drops, then 0 and 3 follow.
        do_reset();
        bus.rr_mode = 1'b1; bus.req = 8'b0000_1001;
        rst = 1'b0;
        cycle();
        chk("bp_first_valid", 64'(bus.grant_valid), 64'd1);
        chk("bp_first_idx", 64'(bus.grant_idx), 64'd3);
        bus.req = 8'b0000_0001;
        repeat (4) begin
            cycle();
            chk("bp_hold_idx", 64'(bus.grant_idx), 64'd3);
            chk("bp_hold_onehot", 64'(bus.grant_onehot), 64'h08);
        end
        bus.req = 8'b0000_1001;
        bus.grant_ready = 1'b1;
        exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(3);
        repeat (3) cycle();
        bus.grant_ready = 1'b0;

        // Mode switch: RR grant 4 leaves ptr=3, fixed grants keep it, RR resumes at 3.
        do_reset();
        bus.rr_mode = 1'b1; bus.req = 8'b0001_0000; bus.grant_ready = 1'b1;
        exp_q.push_back(4);
        rst = 1'b0;
        cycle();
        bus.rr_mode = 1'b0; bus.req = 8'b0001_1000;
        repeat (3) exp_q.push_back(4);
        repeat (3) cycle();
        chk("switch_ptr", 64'(dut.r_ptr), 64'd3);
        bus.rr_mode = 1'b1;
        exp_q.push_back(3);
        repeat (2) cycle();
        bus.grant_ready = 1'b0;

        // Reset mid-grant: asynchronous clear between edges, then fresh grant.
        do_reset();
        bus.rr_mode = 1'b0; bus.req = 8'hFF;
        rst = 1'b0;
        cycle();
        chk("mid_pre_idx", 64'(bus.grant_idx), 64'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.grant_valid), 64'd0);
        chk("mid_rst_idx", 64'(bus.grant_idx), 64'd0);
        chk("mid_rst_onehot", 64'(bus.grant_onehot), 64'd0);
        bus.req = 8'h01;
        rst = 1'b0;
        cycle();
        chk("mid_after_valid", 64'(bus.grant_valid), 64'd1);
        chk("mid_after_idx", 64'(bus.grant_idx), 64'd0);
        chk("mid_after_onehot", 64'(bus.grant_onehot), 64'h01);

        cycle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_priority_encoder_rr
